// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiter.
package axis_packet_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Upper bound on requesters handled by the round-robin search.
  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  // Width of an index field; never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of req searching circularly from last_grant+1.
  // Iterating from the far end and overwriting leaves the nearest hit,
  // which avoids a loop break. Returns last_grant when req is empty;
  // callers only use the result when req is nonzero.
  function automatic int rr_next(input logic [RR_MAX_N-1:0] req,
                                 input int                  n,
                                 input int                  last_grant);
    int idx;
    int pick;
    pick = last_grant;
    for (int k = RR_MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = last_grant + 1 + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[RR_IDX_W-1:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_skid_buffer.sv
// axis_skid_buffer: 2-entry FIFO stage with registered output and registered
// ready. Ready is computed from the next-cycle occupancy, so it never has a
// combinational path from the downstream ready.
module axis_skid_buffer #(
  parameter int DWIDTH   = 32,
  parameter int ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid_i,
  input  logic [DWIDTH-1:0]   in_data_i,
  input  logic                in_last_i,
  input  logic [ID_WIDTH-1:0] in_id_i,
  output logic                in_ready_o,
  output logic                out_valid_o,
  output logic [DWIDTH-1:0]   out_data_o,
  output logic                out_last_o,
  output logic [ID_WIDTH-1:0] out_id_o,
  input  logic                out_ready_i
);

  logic [1:0]          count_q, count_d;
  logic                ready_q, ready_d;
  logic [DWIDTH-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [ID_WIDTH-1:0] head_id_q, head_id_d, tail_id_q, tail_id_d;
  logic                push;
  logic                pop;

  assign push = in_valid_i & ready_q;
  assign pop  = (count_q != 2'd0) & out_ready_i;

  // Next occupancy and entry contents; the head entry always feeds the output.
  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    head_id_d   = head_id_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    tail_id_d   = tail_id_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = in_data_i;
          head_last_d = in_last_i;
          head_id_d   = in_id_i;
        end else begin
          tail_data_d = in_data_i;
          tail_last_d = in_last_i;
          tail_id_d   = in_id_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        head_id_d   = tail_id_q;
        count_d     = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          head_id_d   = tail_id_q;
          tail_data_d = in_data_i;
          tail_last_d = in_last_i;
          tail_id_d   = in_id_i;
        end else begin
          head_data_d = in_data_i;
          head_last_d = in_last_i;
          head_id_d   = in_id_i;
        end
      end
      default: ;
    endcase
    ready_d = (count_d != 2'd2);
  end

  // Storage and occupancy registers; empty and ready out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q     <= 2'd0;
      ready_q     <= 1'b1;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      head_id_q   <= '0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      tail_id_q   <= '0;
    end else begin
      count_q     <= count_d;
      ready_q     <= ready_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      head_id_q   <= head_id_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      tail_id_q   <= tail_id_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_data_q;
  assign out_last_o  = head_last_q;
  assign out_id_o    = head_id_q;

endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-atomic round-robin arbiter sharing one
// AXI-stream sink among N_INPUTS requesters, output through a skid buffer.
//
// state  | meaning
// IDLE   | nobody owns the output; evaluate requests, all in_ready low
// LOCKED | grant held until the granted input's last beat is accepted
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int N_INPUTS = 4,
  parameter int ID_WIDTH = clog2_min1(N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_INPUTS*DWIDTH-1:0]   in_data,
  input  logic [N_INPUTS-1:0]          in_valid,
  input  logic [N_INPUTS-1:0]          in_last,
  output logic [N_INPUTS-1:0]          in_ready,
  output logic [DWIDTH-1:0]            out_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [ID_WIDTH-1:0]          out_id,
  input  logic                         out_ready,
  input  logic                         enable,
  input  logic [N_INPUTS-1:0]          mask,
  output logic                         busy
);

  localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(N_INPUTS - 1);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [N_INPUTS-1:0] req;
  logic [DWIDTH-1:0]   sel_data;
  logic                sel_valid;
  logic                sel_last;
  logic                skid_ready;
  logic                push;

  // mask and enable only gate new grants; a locked packet ignores them.
  assign req = in_valid & mask & {N_INPUTS{enable}};

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_INIT;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Select the granted requester's stream.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_data  = in_data[i*DWIDTH +: DWIDTH];
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
      end
    end
  end

  // Next state: grant in IDLE, release after the last beat is accepted.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = ID_WIDTH'(rr_next(RR_MAX_N'(req), N_INPUTS, int'(last_grant_q)));
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (push && sel_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: only the granted input sees the registered skid ready.
  always_comb begin
    in_ready = '0;
    busy     = (state_q == LOCKED);
    if (state_q == LOCKED) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (grant_q == ID_WIDTH'(i)) in_ready[i] = skid_ready;
      end
    end
    push = busy & sel_valid & skid_ready;
  end

  axis_skid_buffer #(
    .DWIDTH   (DWIDTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (push),
    .in_data_i   (sel_data),
    .in_last_i   (sel_last),
    .in_id_i     (grant_q),
    .in_ready_o  (skid_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_id_o    (out_id),
    .out_ready_i (out_ready)
  );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter with a packet-level reference model.
module tb_axis_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic [IW-1:0]   out_id;
  logic            out_ready = 1'b1;
  logic            enable = 1'b1;
  logic [N-1:0]    mask = '1;
  logic            busy;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.DWIDTH(DW), .N_INPUTS(N)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_id(out_id),
    .out_ready(out_ready), .enable(enable), .mask(mask), .busy(busy)
  );

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct {logic [DW-1:0] data; logic last; int id;} exp_t;

  beat_t    pq[N][$];
  exp_t     sb[$];
  int       grant_log[$];
  bit       m_locked = 1'b0;
  int       m_grant = 0;
  int       m_last = N - 1;
  logic [N-1:0] acc_vec = '0;
  int       acc_cnt[N];
  int       pops = 0;
  int       n_vec = 0;
  int       n_err = 0;
  int       gap_pct = 0;
  bit       rdy_rand = 1'b0;
  int       rdy_pct = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor / reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [N-1:0] req;
    logic [N-1:0] acc;
    int occ;
    exp_t e;
    occ = sb.size();
    exp_rdy = '0;
    if (m_locked && occ < 2) exp_rdy[m_grant] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(m_locked));
    chk("out_valid", 64'(out_valid), 64'(occ > 0));
    if (occ > 0) begin
      e = sb[0];
      chk("out_data", 64'(out_data), 64'(e.data));
      chk("out_last", 64'(out_last), 64'(e.last));
      chk("out_id", 64'(out_id), 64'(e.id));
      if (out_ready) begin
        void'(sb.pop_front());
        pops++;
      end
    end
    acc = in_valid & exp_rdy;
    if (m_locked && acc[m_grant]) begin
      e.data = in_data[m_grant*DW +: DW];
      e.last = in_last[m_grant];
      e.id   = m_grant;
      sb.push_back(e);
      acc_cnt[m_grant]++;
    end
    if (!m_locked) begin
      req = in_valid & mask & {N{enable}};
      if (req != '0) begin
        m_grant  = rr_pick(req, m_last);
        m_locked = 1'b1;
        grant_log.push_back(m_grant);
      end
    end else if (acc[m_grant] && in_last[m_grant]) begin
      m_last   = m_grant;
      m_locked = 1'b0;
    end
    if (!reset_n) begin
      sb.delete();
      grant_log.delete();
      m_locked = 1'b0;
      m_last   = N - 1;
      acc      = '0;
    end
    acc_vec = acc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_vec[i] && in_valid[i]) begin
        void'(pq[i].pop_front());
        in_valid[i] = 1'b0;
      end
      if (!in_valid[i] && pq[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_valid[i] = 1'b1;
        in_data[i*DW +: DW] = pq[i][0].data;
        in_last[i] = pq[i][0].last;
      end
    end
    if (rdy_rand) out_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) pq[i].delete();
    in_valid = '0;
    in_last  = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush();
    mask = '1; enable = 1'b1; out_ready = 1'b1; rdy_rand = 1'b0; gap_pct = 0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic load_pkt(input int src, input int len, input logic [DW-1:0] first, input bit rnd);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.data = rnd ? DW'($urandom) : first + DW'(b);
      bt.last = (b == len - 1);
      pq[src].push_back(bt);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (sb.size() > 0) || m_locked || (in_valid != '0);
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name, input int max);
    int c;
    c = 0;
    while (pending() && c < max) begin
      tick();
      c++;
    end
    chk({name, " drain timeout"}, 64'(pending()), 64'(0));
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int a0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;

    // Reset state.
    do_reset();
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_last", 64'(out_last), 64'(0));
    chk("rst out_data", 64'(out_data), 64'(0));
    chk("rst out_id", 64'(out_id), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(0));

    // Single 3-beat packet on input 0.
    p0 = pops;
    load_pkt(0, 3, 32'hA1, 1'b0);
    drain("t1", 50);
    chk("t1 grants", 64'(grant_log.size()), 64'(1));
    if (grant_log.size() >= 1) chk("t1 grant0", 64'(grant_log[0]), 64'(0));
    chk("t1 beats", 64'(pops - p0), 64'(3));

    // All inputs with back-to-back 2-beat packets.
    do_reset();
    for (int i = 0; i < N; i++) begin
      load_pkt(i, 2, 0, 1'b1);
      load_pkt(i, 2, 0, 1'b1);
    end
    drain("t2", 200);
    chk("t2 grants", 64'(grant_log.size()), 64'(8));
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("t2 order", 64'(grant_log[k]), 64'(k % 4));

    // Backpressure on a 6-beat packet from input 2.
    do_reset();
    p0 = pops;
    load_pkt(2, 6, 32'h200, 1'b0);
    begin
      logic pat[9];
      pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tick();
      for (int k = 0; k < 9; k++) begin
        out_ready = pat[k];
        tick();
      end
      out_ready = 1'b1;
    end
    drain("t3", 100);
    chk("t3 beats", 64'(pops - p0), 64'(6));

    // Mask skips input 2; clearing mask[1] mid-packet lets it finish.
    do_reset();
    mask = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      load_pkt(1, 3, 0, 1'b1);
      load_pkt(3, 2, 0, 1'b1);
    end
    load_pkt(2, 2, 0, 1'b1);
    for (int c = 0; c < 300 && grant_log.size() < 5; c++) tick();
    mask = 4'b1001;
    for (int c = 0; c < 300 && (pq[3].size() > 0 || sb.size() > 0 || m_locked); c++) tick();
    repeat (5) tick();
    chk("t4 grants", 64'(grant_log.size()), 64'(6));
    begin
      int exp4[6];
      exp4 = '{1, 3, 1, 3, 1, 3};
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
        chk("t4 order", 64'(grant_log[k]), 64'(exp4[k]));
    end

    // Enable dropped during input 1's packet.
    do_reset();
    load_pkt(1, 4, 0, 1'b1);
    load_pkt(1, 2, 0, 1'b1);
    load_pkt(2, 2, 0, 1'b1);
    for (int c = 0; c < 50 && grant_log.size() < 1; c++) tick();
    enable = 1'b0;
    repeat (20) tick();
    chk("t5 no grant", 64'(grant_log.size()), 64'(1));
    chk("t5 busy low", 64'(busy), 64'(0));
    if (grant_log.size() >= 1) chk("t5 first", 64'(grant_log[0]), 64'(1));
    enable = 1'b1;
    for (int c = 0; c < 50 && grant_log.size() < 2; c++) tick();
    chk("t5 second", 64'(grant_log.size() >= 2 ? grant_log[1] : -1), 64'(2));
    drain("t5", 100);

    // Reset during beat 2 of input 3's packet.
    do_reset();
    a0 = acc_cnt[3];
    load_pkt(3, 4, 32'h300, 1'b0);
    for (int c = 0; c < 50 && acc_cnt[3] < a0 + 1; c++) tick();
    reset_n = 1'b0;
    flush();
    tick();
    reset_n = 1'b1;
    chk("t6 out_valid", 64'(out_valid), 64'(0));
    chk("t6 in_ready", 64'(in_ready), 64'(0));
    chk("t6 busy", 64'(busy), 64'(0));
    load_pkt(0, 1, 32'h0A, 1'b0);
    load_pkt(3, 1, 32'h3A, 1'b0);
    drain("t6", 50);
    chk("t6 grants", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() >= 2) begin
      chk("t6 first", 64'(grant_log[0]), 64'(0));
      chk("t6 second", 64'(grant_log[1]), 64'(3));
    end

    // Random traffic, masks, enable and backpressure.
    do_reset();
    gap_pct = 30;
    rdy_rand = 1'b1;
    rdy_pct = 70;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (pq[i].size() < 4 && $urandom_range(9) == 0)
          load_pkt(i, int'($urandom_range(4, 1)), 0, 1'b1);
      if (c % 60 == 0) begin
        mask = N'($urandom);
        enable = ($urandom_range(5) != 0);
      end
      tick();
    end
    mask = '1;
    enable = 1'b1;
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    gap_pct = 0;
    drain("rand", 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
